posit_decoder: RTL and testbench
================================

# posit_decoder

Iterative 32-bit posit (es = 3) decoder that unpacks a posit word into sign, regime value k, exponent and left-aligned fraction. It is the inverse of `posit_encoder`, and its output fields use the same formats as that block's inputs, so a decoded word can be re-encoded directly. It sits at the unpack stage of the posit datapath and uses the same level start / done handshake as the encoder.

## Interface
- No parameters. Format is fixed: N = 32, es = 3.
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, asynchronous, active-low (0 = reset)
- start  in  1  level request; sampled only in IDLE
- posit_in  in  32  posit word; sampled on the accepting edge only
- sign_out  out  1  sign bit of the posit
- k_out  out  6 signed  regime value; range [-30, 30] for normal words
- exp_out  out  3  exponent field; bits truncated by the regime read as 0
- mantissa_out  out  32  fraction bits, MSB-aligned at bit 31, zero-filled, hidden bit excluded
- zero  out  1  input was 0x00000000
- nar  out  1  input was 0x80000000 (see Configuration)
- done  out  1  result valid

## Operation
- States are IDLE, SCAN, EXTRACT and DONE.
- **IDLE with start = 1:** capture posit_in.
  - If the word is special (0x00000000, or 0x80000000), write the outputs directly and go to DONE.
  - Otherwise set sign = bit31 and mag = sign ? two's complement of posit_in : posit_in.
  - Load shreg = mag, runbit = mag[30], m = 0, then go to SCAN.
- **SCAN:** one bit per cycle.
  - If shreg[30] == runbit, shift shreg left by 1 (zero-fill) and increment m (6-bit counter).
  - Otherwise go to EXTRACT. The terminator is now at shreg[30].
  - A full-length run terminates naturally on the zero fill, so the maximum m is 31.
- **EXTRACT:** register the outputs and go to DONE.
  - k_out = runbit ? m − 1 : −m
  - exp_out = shreg[29:27]
  - mantissa_out = {shreg[26:0], 5'b0}
  - sign_out = sign; zero = nar = 0
- **Special words:**
  - 0x00000000: zero = 1; sign_out, k_out, exp_out and mantissa_out are all 0.
  - 0x80000000 with the macro defined: nar = 1, sign_out = 1, other fields 0.
- **DONE:** done = 1. Stay in DONE while start = 1. Go to IDLE when start = 0; done clears on that edge.
- Outputs hold their last result until the next completion. Results are never partially updated.
- start deasserted during SCAN or EXTRACT is ignored. The operation completes, and done is then high for exactly one cycle.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE
  - done, sign_out, zero and nar = 0
  - k_out = 0, exp_out = 0, mantissa_out = 0
  - Internal shreg and m are cleared.
  - Reset mid-operation aborts with no output update; start still high after release begins a new decode.
- **Normal word** with run length m: accepted at edge E0, SCAN occupies E1..E(m+1), EXTRACT is E(m+2). done is high after E(m+2), so latency = m + 2 cycles, range 3..33.
- **Special word:** done is high after E1 (latency 1).
- **Back-to-back:** minimum gap between accepts is one IDLE cycle after start falls.
- posit_in may change freely after the accepting edge.

## Configuration
- **POSIT_DEC_NAR_EN defined:** 0x80000000 sets nar = 1, sign_out = 1 and zero = 0.
- **POSIT_DEC_NAR_EN undefined:** the nar port remains and is tied 0. 0x80000000 is reported as zero = 1 with sign_out = 1, other fields 0, at latency 1.

## Test plan
- **Positive word.** posit_in = 0x7E9FFE00 → sign 0, k 5, exp 4, mantissa 0xFFF00000, done 8 cycles after accept.
- **Negative word.** posit_in = 0x81600200 → sign 1, k 5, exp 4, mantissa 0xFFF00000, latency 8.
- **Regime extremes.**
  - 0x7FFFFFFF → k 30, exp 0, mantissa 0, latency 33.
  - 0x00000001 → k −30, exp 0, mantissa 0, latency 32.
  - 0x40000000 → k 0, exp 0, mantissa 0, latency 3.
- **Special words.**
  - 0x00000000 → zero = 1, all fields 0, latency 1.
  - 0x80000000 → nar = 1, sign 1 with POSIT_DEC_NAR_EN; zero = 1, nar = 0 without.
- **Handshake.**
  - Hold start through done → done stays high until start falls, then low next edge.
  - Drop start mid-SCAN → result still delivered, done high for exactly one cycle.
- **Reset mid-SCAN.** Pull rst = 0 during SCAN of 0x7FFFFFFF → all outputs 0 immediately, no done. Release with start = 1 and posit_in = 0x40000000 → k 0 after 3 cycles.

Source files
------------

// File: rtl/posit_decoder.sv
// ============================================================================
// posit_decoder : iterative 32-bit posit (es = 3) unpacker, one regime bit/cycle
// Optional macro POSIT_DEC_NAR_EN enables NaR reporting on the nar output.
// Revision 1.0
// ============================================================================
`default_nettype none

module posit_decoder (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        posit_in,
   output logic               sign_out,
   output logic signed [5:0]  k_out,
   output logic [2:0]         exp_out,
   output logic [31:0]        mantissa_out,
   output logic               zero,
   output logic               nar,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      EXTRACT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      state;
   logic [30:0] shreg;
   logic [5:0]  m;
   logic        runbit;
   logic        sign;

   logic [30:0] mag;
   logic        special;

   // Bit 31 of the magnitude is always 0 for non-special words, so 31 bits suffice.
   assign mag     = posit_in[31] ? (~posit_in[30:0] + 31'd1) : posit_in[30:0];
   assign special = (posit_in[30:0] == 31'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         shreg        <= '0;
         m            <= '0;
         runbit       <= 1'b0;
         sign         <= 1'b0;
         sign_out     <= 1'b0;
         k_out        <= '0;
         exp_out      <= '0;
         mantissa_out <= '0;
         zero         <= 1'b0;
         nar          <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (special) begin
                     sign_out     <= posit_in[31];
                     k_out        <= '0;
                     exp_out      <= '0;
                     mantissa_out <= '0;
`ifdef POSIT_DEC_NAR_EN
                     zero         <= ~posit_in[31];
                     nar          <= posit_in[31];
`else
                     zero         <= 1'b1;
                     nar          <= 1'b0;
`endif
                     done         <= 1'b1;
                     state        <= DONE;
                  end else begin
                     sign   <= posit_in[31];
                     shreg  <= mag;
                     runbit <= mag[30];
                     m      <= '0;
                     state  <= SCAN;
                  end
               end
            end
            SCAN: begin
               // An all-ones run ends on the zero fill, bounding m at 31.
               if (shreg[30] == runbit) begin
                  shreg <= {shreg[29:0], 1'b0};
                  m     <= m + 6'd1;
               end else begin
                  state <= EXTRACT;
               end
            end
            EXTRACT: begin
               sign_out     <= sign;
               k_out        <= runbit ? (m - 6'd1) : (6'd0 - m);
               exp_out      <= shreg[29:27];
               mantissa_out <= {shreg[26:0], 5'b0};
               zero         <= 1'b0;
               nar          <= 1'b0;
               done         <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (!start) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_posit_decoder.sv
// ============================================================================
// tb_posit_decoder : self-checking bench for posit_decoder with a reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_posit_decoder;

   logic               clk;
   logic               rst;
   logic               start;
   logic [31:0]        posit_in;
   logic               sign_out;
   logic signed [5:0]  k_out;
   logic [2:0]         exp_out;
   logic [31:0]        mantissa_out;
   logic               zero;
   logic               nar;
   logic               done;

   int checks = 0;
   int errors = 0;

   posit_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .posit_in     (posit_in),
      .sign_out     (sign_out),
      .k_out        (k_out),
      .exp_out      (exp_out),
      .mantissa_out (mantissa_out),
      .zero         (zero),
      .nar          (nar),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [43:0] outs();
      return {sign_out, k_out, exp_out, mantissa_out, zero, nar};
   endfunction

   // Reference model: walks the posit bit string directly.
   task automatic ref_decode(input logic [31:0] p, output logic [43:0] fields, output int lat);
      logic [31:0] v;
      logic [63:0] rest;
      logic        r, s, z, n;
      logic [5:0]  k;
      int          idx, run;
      s = p[31]; z = 1'b0; n = 1'b0; k = '0; rest = '0; lat = 1;
      if (p == 32'h0) begin
         z = 1'b1;
      end else if (p == 32'h8000_0000) begin
`ifdef POSIT_DEC_NAR_EN
         n = 1'b1;
`else
         z = 1'b1;
`endif
      end else begin
         v = s ? -p : p;
         r = v[30]; run = 0; idx = 30;
         while (idx >= 0 && v[idx] == r) begin
            run++;
            idx--;
         end
         k = r ? 6'(run - 1) : 6'(-run);
         if (idx > 0) rest = {32'd0, v} << (64 - idx);
         lat = run + 2;
      end
      fields = {s, k, rest[63:61], rest[60:29], z, n};
   endtask

   // Stimulus driver: accepts p, waits for done, reports latency and output stability.
   task automatic run_op(input logic [31:0] p, input int drop_at, output int lat, output bit held);
      logic [43:0] snap;
      snap = outs();
      posit_in = p;
      start    = 1'b1;
      @(posedge clk);
      #1 posit_in = $urandom;
      lat = 0; held = 1'b1;
      while (lat < 40) begin
         @(posedge clk);
         #1 lat++;
         if (done) break;
         if (outs() !== snap) held = 1'b0;
         if (lat == drop_at) start = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; posit_in = '0;
      repeat (3) @(posedge clk);
      #1 checks++;
      if ({outs(), done} !== 45'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {outs(), done});
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_done got=%b exp=0", done);
      end
   endtask

   task automatic test_directed();
      logic [31:0] dp [5] = '{32'h7E9F_FE00, 32'h8160_0200, 32'h7FFF_FFFF, 32'h0000_0001, 32'h4000_0000};
      logic [43:0] de [5] = '{{1'b0, 6'd5, 3'd4, 32'hFFF0_0000, 2'b00},
                              {1'b1, 6'd5, 3'd4, 32'hFFF0_0000, 2'b00},
                              {1'b0, 6'd30, 3'd0, 32'h0, 2'b00},
                              {1'b0, 6'h22, 3'd0, 32'h0, 2'b00},
                              {1'b0, 6'd0, 3'd0, 32'h0, 2'b00}};
      int dl [5] = '{8, 8, 33, 32, 3};
      int lat;
      bit held;
      for (int i = 0; i < 5; i++) begin
         run_op(dp[i], 0, lat, held);
         checks += 2;
         if (outs() !== de[i]) begin
            errors++;
            $display("FAIL directed_fields p=%h got=%h exp=%h", dp[i], outs(), de[i]);
         end
         if (lat != dl[i]) begin
            errors++;
            $display("FAIL directed_latency p=%h got=%0d exp=%0d", dp[i], lat, dl[i]);
         end
         start = 1'b0;
         @(posedge clk);
         #1 checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL directed_done_clear p=%h got=%b exp=0", dp[i], done);
         end
      end
   endtask

   task automatic test_special();
      logic [43:0] exp_nar;
      int lat;
      bit held;
`ifdef POSIT_DEC_NAR_EN
      exp_nar = {1'b1, 6'd0, 3'd0, 32'h0, 2'b01};
`else
      exp_nar = {1'b1, 6'd0, 3'd0, 32'h0, 2'b10};
`endif
      run_op(32'h0000_0000, 0, lat, held);
      checks += 2;
      if (outs() !== {1'b0, 6'd0, 3'd0, 32'h0, 2'b10}) begin
         errors++;
         $display("FAIL special_zero got=%h", outs());
      end
      if (lat != 1) begin
         errors++;
         $display("FAIL special_zero_latency got=%0d exp=1", lat);
      end
      start = 1'b0;
      @(posedge clk);
      #1 run_op(32'h8000_0000, 0, lat, held);
      checks += 2;
      if (outs() !== exp_nar) begin
         errors++;
         $display("FAIL special_nar got=%h exp=%h", outs(), exp_nar);
      end
      if (lat != 1) begin
         errors++;
         $display("FAIL special_nar_latency got=%0d exp=1", lat);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [31:0] p;
      logic [43:0] ef;
      int el, lat;
      bit held;
      for (int i = 0; i < 60; i++) begin
         p = $urandom;
         if (i % 2 == 1) p = p >> $urandom_range(0, 31);
         if (i % 4 == 3) p = ~p;
         ref_decode(p, ef, el);
         run_op(p, 0, lat, held);
         checks += 3;
         if (outs() !== ef) begin
            errors++;
            $display("FAIL random_fields p=%h got=%h exp=%h", p, outs(), ef);
         end
         if (lat != el) begin
            errors++;
            $display("FAIL random_latency p=%h got=%0d exp=%0d", p, lat, el);
         end
         if (!held) begin
            errors++;
            $display("FAIL random_hold p=%h got=changed exp=stable", p);
         end
         start = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_hold_start();
      int lat;
      bit held;
      run_op(32'h4000_0000, 0, lat, held);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 checks++;
         if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done cycle=%0d got=%b exp=1", i, done);
         end
      end
      start = 1'b0;
      @(posedge clk);
      #1 checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL hold_release got=%b exp=0", done);
      end
   endtask

   task automatic test_drop_start();
      int lat;
      bit held;
      run_op(32'h7FFF_FFFF, 4, lat, held);
      checks += 2;
      if (done !== 1'b1 || lat != 33) begin
         errors++;
         $display("FAIL drop_done got=%b/%0d exp=1/33", done, lat);
      end
      if (outs() !== {1'b0, 6'd30, 3'd0, 32'h0, 2'b00}) begin
         errors++;
         $display("FAIL drop_fields got=%h", outs());
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL drop_one_cycle cycle=%0d got=%b exp=0", i, done);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      bit held;
      posit_in = 32'h7FFF_FFFF;
      start    = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1 checks++;
      if ({outs(), done} !== 45'd0) begin
         errors++;
         $display("FAIL reset_mid_scan got=%h exp=0", {outs(), done});
      end
      posit_in = 32'h4000_0000;
      @(negedge clk) rst = 1'b1;
      run_op(32'h4000_0000, 0, lat, held);
      checks += 2;
      if (outs() !== 44'd0) begin
         errors++;
         $display("FAIL reset_restart_fields got=%h exp=0", outs());
      end
      if (lat != 3) begin
         errors++;
         $display("FAIL reset_restart_latency got=%0d exp=3", lat);
      end
      start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_special();
      test_random();
      test_hold_start();
      test_drop_start();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
